// File: rtl/l1_mem_arbiter_if.sv
// Bus bundle between the two L1 requesters, the arbiter and mainMem.
// Ports: requester 0/1 request side, mainMem handshake, grant status and counters.
interface l1_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              REQ0;
    logic              REQ1;
    logic              WE0;
    logic              WE1;
    logic [ADDR_W-1:0] ADDR0;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDATA0;
    logic [DATA_W-1:0] WDATA1;
    logic              ACK0;
    logic              ACK1;
    logic              ERR0;
    logic              ERR1;
    logic [DATA_W-1:0] RDATA0;
    logic [DATA_W-1:0] RDATA1;
    logic [ADDR_W-1:0] Mem_Address;
    logic [DATA_W-1:0] Mem_WData;
    logic [DATA_W-1:0] Mem_RData;
    logic              Mem_Request;
    logic              MEM_WE;
    logic              MEM_ACK;
    logic              GRANT_ID;
    logic              BUSY;
    logic [15:0]       GNT_CNT0;
    logic [15:0]       GNT_CNT1;

    // Arbiter side.
    modport slave (
        input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
        input  Mem_RData, MEM_ACK,
        output ACK0, ACK1, ERR0, ERR1, RDATA0, RDATA1,
        output Mem_Address, Mem_WData, Mem_Request, MEM_WE,
        output GRANT_ID, BUSY, GNT_CNT0, GNT_CNT1
    );

    // Requester / memory side.
    modport master (
        output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
        output Mem_RData, MEM_ACK,
        input  ACK0, ACK1, ERR0, ERR1, RDATA0, RDATA1,
        input  Mem_Address, Mem_WData, Mem_Request, MEM_WE,
        input  GRANT_ID, BUSY, GNT_CNT0, GNT_CNT1
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared mainMem port (I-side L1 = 0, D-side L1 = 1).
// Ports: clk, rst_n (async, active-low), io_bus (slave modport of l1_mem_arbiter_if).
module l1_mem_arbiter #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    l1_mem_arbiter_if.slave      io_bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_MEM_REL,
        S_CPU_ACK
    } state_t;

    localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_last;
    logic              r_gid;
    logic [15:0]       r_tcnt;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_req;
    logic              r_we;
    logic [15:0]       r_gnt_cnt0;
    logic [15:0]       r_gnt_cnt1;

    logic w_any;
    logic w_pick;
    logic w_req_cur;

    assign w_any = io_bus.REQ0 | io_bus.REQ1;
    // On a tie the port that did not win last time gets the grant.
    assign w_pick = (io_bus.REQ0 & io_bus.REQ1) ? ~r_last : io_bus.REQ1;
    assign w_req_cur = r_gid ? io_bus.REQ1 : io_bus.REQ0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_gid      <= 1'b0;
            r_tcnt     <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_addr  <= w_pick ? io_bus.ADDR1 : io_bus.ADDR0;
                        r_we    <= w_pick ? io_bus.WE1 : io_bus.WE0;
                        r_wdata <= w_pick ? io_bus.WDATA1 : io_bus.WDATA0;
                        r_req   <= 1'b1;
                        r_gid   <= w_pick;
                        r_tcnt  <= '0;
                        if (w_pick) begin
                            if (r_gnt_cnt1 != 16'hFFFF)
                                r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
                        end else begin
                            if (r_gnt_cnt0 != 16'hFFFF)
                                r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
                        end
                        r_state <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (io_bus.MEM_ACK) begin
                        r_req <= 1'b0;
                        if (r_gid) begin
                            if (!r_we) r_rdata1 <= io_bus.Mem_RData;
                            r_err1 <= 1'b0;
                        end else begin
                            if (!r_we) r_rdata0 <= io_bus.Mem_RData;
                            r_err0 <= 1'b0;
                        end
                        r_state <= S_MEM_REL;
                    end else if (r_tcnt == TMAX) begin
                        // Watchdog abort: report error data to the owner.
                        r_req <= 1'b0;
                        if (r_gid) begin
                            r_rdata1 <= ERR_DATA;
                            r_err1   <= 1'b1;
                        end else begin
                            r_rdata0 <= ERR_DATA;
                            r_err0   <= 1'b1;
                        end
                        r_state <= S_MEM_REL;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_MEM_REL: begin
                    if (!io_bus.MEM_ACK) begin
                        if (r_gid) r_ack1 <= 1'b1;
                        else       r_ack0 <= 1'b1;
                        r_state <= S_CPU_ACK;
                    end
                end
                S_CPU_ACK: begin
                    if (!w_req_cur) begin
                        if (r_gid) begin
                            r_ack1 <= 1'b0;
                            r_err1 <= 1'b0;
                        end else begin
                            r_ack0 <= 1'b0;
                            r_err0 <= 1'b0;
                        end
                        r_we    <= 1'b0;
                        r_last  <= r_gid;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign io_bus.ACK0        = r_ack0;
    assign io_bus.ACK1        = r_ack1;
    assign io_bus.ERR0        = r_err0;
    assign io_bus.ERR1        = r_err1;
    assign io_bus.RDATA0      = r_rdata0;
    assign io_bus.RDATA1      = r_rdata1;
    assign io_bus.Mem_Address = r_addr;
    assign io_bus.Mem_WData   = r_wdata;
    assign io_bus.Mem_Request = r_req;
    assign io_bus.MEM_WE      = r_we;
    assign io_bus.GRANT_ID    = r_gid;
    assign io_bus.BUSY        = (r_state != S_IDLE);
    assign io_bus.GNT_CNT0    = r_gnt_cnt0;
    assign io_bus.GNT_CNT1    = r_gnt_cnt1;
endmodule
